// File: rtl/led_pkg.sv
// Shared encodings for the LED frame buffer: display modes and the blank colour.
package led_pkg;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_OFF   = 2'd2;

    // Wide enough for any practical colour depth; users slice the low COLOR_W bits.
    localparam int                     COLOR_MAX_W = 256;
    localparam logic [COLOR_MAX_W-1:0] COLOR_OFF   = '0;

endpackage

// File: rtl/led_status_enc.sv
// Lowest-lit-index priority encoder and lit-LED popcount over per-LED non-zero flags.
module led_status_enc
    import led_pkg::*;
#(
    parameter int N_LEDS = 5,
    parameter int IDX_W  = $clog2(N_LEDS)
) (
    input  logic [N_LEDS-1:0] i_nz,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_any,
    output logic [IDX_W:0]    o_count
);

    localparam int CNT_W = IDX_W + 1;

    always_comb begin
        o_index = '0;
        o_count = '0;
        // Scan downward so the lowest set flag is the last one written.
        for (int i = N_LEDS - 1; i >= 0; i--) begin
            if (i_nz[i]) o_index = IDX_W'(i);
        end
        for (int i = 0; i < N_LEDS; i++) begin
            o_count = o_count + CNT_W'(i_nz[i]);
        end
        o_any = |i_nz;
    end

endmodule

// File: rtl/led_frame_buffer_n.sv
// Double-buffered LED colour store: shadow writes, frame-synchronised commit to the
// active frame, blink/off display modes and registered lit-LED status.
module led_frame_buffer_n
    import led_pkg::*;
#(
    parameter int N_LEDS      = 5,
    parameter int COLOR_W     = 24,
    parameter int IDX_W       = $clog2(N_LEDS),
    parameter int BLINK_TICKS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_load_frame,
    input  logic [N_LEDS-1:0]         i_load_mask,
    input  logic [COLOR_W-1:0]        i_load_color,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [IDX_W-1:0]          i_wr_index,
    input  logic [COLOR_W-1:0]        i_wr_color,
    output logic                      o_wr_err,
    input  logic [1:0]                i_mode,
    input  logic                      i_commit_req,
    input  logic                      i_frame_tick,
    output logic                      o_commit_ack,
    output logic [N_LEDS*COLOR_W-1:0] o_leds,
    output logic [IDX_W-1:0]          o_led_index,
    output logic                      o_any_on,
    output logic [IDX_W:0]            o_lit_count
);

    localparam int                 CNT_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_TICKS - 1);
    localparam logic [COLOR_W-1:0] C_OFF    = COLOR_OFF[COLOR_W-1:0];

    typedef logic [N_LEDS-1:0][COLOR_W-1:0] frame_t;

    frame_t           r_shadow, r_active, r_leds;
    frame_t           w_shadow_nx, w_active_nx, w_leds_nx;
    logic             r_pending, r_wr_err, r_ack, r_phase, w_phase_nx;
    logic [1:0]       r_mode, w_mode_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             w_accept, w_copy, w_idx_ok;
    logic [N_LEDS-1:0] w_nz;
    logic [IDX_W-1:0] w_index, r_led_index;
    logic             w_any, r_any_on;
    logic [IDX_W:0]   w_count, r_lit_count;

    assign w_accept = !r_pending;
    assign w_idx_ok = int'(i_wr_index) < N_LEDS;
    assign w_copy   = i_frame_tick && (r_pending || i_commit_req);

    // Bulk load first, then the single write overrides its own LED.
    always_comb begin
        w_shadow_nx = r_shadow;
        if (w_accept && i_load_frame) begin
            for (int i = 0; i < N_LEDS; i++) begin
                w_shadow_nx[i] = i_load_mask[i] ? i_load_color : C_OFF;
            end
        end
        if (w_accept && i_wr_valid && w_idx_ok) begin
            w_shadow_nx[i_wr_index] = i_wr_color;
        end
    end

    always_comb begin
        w_active_nx = r_active;
        w_mode_nx   = r_mode;
        w_cnt_nx    = r_cnt;
        w_phase_nx  = r_phase;
        if (w_copy) begin
            w_active_nx = w_shadow_nx;
            w_mode_nx   = (i_mode == MODE_BLINK || i_mode == MODE_OFF) ? i_mode : MODE_SOLID;
            w_cnt_nx    = '0;
            w_phase_nx  = 1'b1;
        end else if (r_mode != MODE_BLINK) begin
            w_cnt_nx    = '0;
            w_phase_nx  = 1'b1;
        end else if (i_frame_tick) begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_nx   = '0;
                w_phase_nx = !r_phase;
            end else begin
                w_cnt_nx   = r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_leds_nx = w_active_nx;
        if (w_mode_nx == MODE_OFF || (w_mode_nx == MODE_BLINK && !w_phase_nx)) begin
            w_leds_nx = {N_LEDS{C_OFF}};
        end
        for (int i = 0; i < N_LEDS; i++) begin
            w_nz[i] = (w_active_nx[i] != C_OFF);
        end
    end

    led_status_enc #(
        .N_LEDS (N_LEDS),
        .IDX_W  (IDX_W)
    ) u_status (
        .i_nz    (w_nz),
        .o_index (w_index),
        .o_any   (w_any),
        .o_count (w_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow    <= '0;
            r_active    <= '0;
            r_leds      <= '0;
            r_mode      <= MODE_SOLID;
            r_pending   <= 1'b0;
            r_wr_err    <= 1'b0;
            r_ack       <= 1'b0;
            r_cnt       <= '0;
            r_phase     <= 1'b1;
            r_led_index <= '0;
            r_any_on    <= 1'b0;
            r_lit_count <= '0;
        end else begin
            r_shadow    <= w_shadow_nx;
            r_active    <= w_active_nx;
            r_leds      <= w_leds_nx;
            r_mode      <= w_mode_nx;
            r_cnt       <= w_cnt_nx;
            r_phase     <= w_phase_nx;
            r_ack       <= w_copy;
            r_led_index <= w_index;
            r_any_on    <= w_any;
            r_lit_count <= w_count;
            if (w_copy)            r_pending <= 1'b0;
            else if (i_commit_req) r_pending <= 1'b1;
            if (w_accept && i_wr_valid && !w_idx_ok) r_wr_err <= 1'b1;
        end
    end

    assign o_wr_ready   = !r_pending;
    assign o_wr_err     = r_wr_err;
    assign o_commit_ack = r_ack;
    assign o_leds       = r_leds;
    assign o_led_index  = r_led_index;
    assign o_any_on     = r_any_on;
    assign o_lit_count  = r_lit_count;

endmodule

// File: tb/tb_led_frame_buffer_n.sv
// Directed bench for led_frame_buffer_n: commit timing, pending write blocking,
// same-cycle merge, blink cadence, out-of-range writes and reset mid-pending.
module tb_led_frame_buffer_n;

    localparam int N  = 5;
    localparam int CW = 24;
    localparam int IW = 3;

    logic              clock, reset;
    logic              load_frame, wr_valid, commit_req, frame_tick;
    logic [N-1:0]      load_mask;
    logic [CW-1:0]     load_color, wr_color;
    logic [IW-1:0]     wr_index;
    logic [1:0]        mode;
    logic              wr_ready, wr_err, commit_ack, any_on;
    logic [N*CW-1:0]   leds;
    logic [IW-1:0]     led_index;
    logic [IW:0]       lit_count;

    int checks   = 0;
    int failures = 0;

    localparam logic [N*CW-1:0] F_ZERO = '0;
    localparam logic [N*CW-1:0] F1 = {24'hFF0000, 24'h000000, 24'hFF0000, 24'h000000, 24'h000000};
    localparam logic [N*CW-1:0] F3 = {24'h0000FF, 24'h123456, 24'h0000FF, 24'h0000FF, 24'h0000FF};

    led_frame_buffer_n #(.N_LEDS(N), .COLOR_W(CW), .IDX_W(IW), .BLINK_TICKS(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_load_frame (load_frame),
        .i_load_mask  (load_mask),
        .i_load_color (load_color),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_index   (wr_index),
        .i_wr_color   (wr_color),
        .o_wr_err     (wr_err),
        .i_mode       (mode),
        .i_commit_req (commit_req),
        .i_frame_tick (frame_tick),
        .o_commit_ack (commit_ack),
        .o_leds       (leds),
        .o_led_index  (led_index),
        .o_any_on     (any_on),
        .o_lit_count  (lit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_frame = 0; wr_valid = 0; commit_req = 0; frame_tick = 0;
        load_mask = '0; load_color = '0; wr_color = '0; wr_index = '0; mode = 2'd0;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (leds !== F_ZERO) begin failures++; $display("FAIL reset_leds got=%h exp=%h", leds, F_ZERO); end
        checks++;
        if ({wr_ready, wr_err, commit_ack} !== 3'b100) begin
            failures++; $display("FAIL reset_ctrl got rdy/err/ack=%b exp=100", {wr_ready, wr_err, commit_ack});
        end
        checks++;
        if ({any_on, lit_count, led_index} !== 8'h00) begin
            failures++; $display("FAIL reset_status got any=%b cnt=%0d idx=%0d exp 0/0/0", any_on, lit_count, led_index);
        end
    endtask

    task automatic test_bulk_commit();
        load_frame = 1; load_mask = 5'b10100; load_color = 24'hFF0000;
        cyc();
        load_frame = 0;
        checks++;
        if (leds !== F_ZERO) begin failures++; $display("FAIL shadow_invisible got=%h exp=%h", leds, F_ZERO); end
        commit_req = 1;
        cyc();
        commit_req = 0;
        checks++;
        if ({wr_ready, commit_ack} !== 2'b00) begin
            failures++; $display("FAIL pending_rdy_ack got=%b exp=00", {wr_ready, commit_ack});
        end
        repeat (2) begin
            cyc();
            checks++;
            if (commit_ack !== 1'b0) begin failures++; $display("FAIL early_ack got=%b exp=0", commit_ack); end
        end
        frame_tick = 1;
        cyc();
        frame_tick = 0;
        checks++;
        if (commit_ack !== 1'b1) begin failures++; $display("FAIL commit_ack got=%b exp=1", commit_ack); end
        checks++;
        if (leds !== F1) begin failures++; $display("FAIL bulk_leds got=%h exp=%h", leds, F1); end
        checks++;
        if ({any_on, lit_count, led_index} !== {1'b1, 4'd2, 3'd2}) begin
            failures++; $display("FAIL bulk_status got any=%b cnt=%0d idx=%0d exp 1/2/2", any_on, lit_count, led_index);
        end
        cyc();
        checks++;
        if ({commit_ack, wr_ready} !== 2'b01) begin
            failures++; $display("FAIL ack_single_pulse got ack/rdy=%b exp=01", {commit_ack, wr_ready});
        end
    endtask

    task automatic test_pending_drop();
        commit_req = 1;
        cyc();
        commit_req = 0;
        wr_valid = 1; wr_index = 3'd1; wr_color = 24'h00FF00;
        load_frame = 1; load_mask = 5'b11111; load_color = 24'h0000FF;
        cyc();
        wr_valid = 0; load_frame = 0;
        checks++;
        if ({wr_ready, wr_err} !== 2'b00) begin
            failures++; $display("FAIL pending_drop_ctrl got rdy/err=%b exp=00", {wr_ready, wr_err});
        end
        frame_tick = 1;
        cyc();
        frame_tick = 0;
        checks++;
        if ({commit_ack, leds} !== {1'b1, F1}) begin
            failures++; $display("FAIL pending_drop_leds got ack=%b leds=%h exp ack=1 leds=%h", commit_ack, leds, F1);
        end
    endtask

    task automatic test_same_cycle();
        cyc();
        load_frame = 1; load_mask = 5'b11111; load_color = 24'h0000FF;
        wr_valid = 1; wr_index = 3'd3; wr_color = 24'h123456;
        commit_req = 1; frame_tick = 1;
        cyc();
        load_frame = 0; wr_valid = 0; commit_req = 0; frame_tick = 0;
        checks++;
        if ({wr_ready, commit_ack} !== 2'b11) begin
            failures++; $display("FAIL same_cycle_ctrl got rdy/ack=%b exp=11", {wr_ready, commit_ack});
        end
        checks++;
        if (leds !== F3) begin failures++; $display("FAIL same_cycle_leds got=%h exp=%h", leds, F3); end
        checks++;
        if ({any_on, lit_count, led_index} !== {1'b1, 4'd5, 3'd0}) begin
            failures++; $display("FAIL same_cycle_status got any=%b cnt=%0d idx=%0d exp 1/5/0", any_on, lit_count, led_index);
        end
        cyc();
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL same_cycle_no_pending got=%b exp=1", wr_ready); end
    endtask

    task automatic test_blink();
        logic [7:0] lit_tbl;
        lit_tbl = 8'b1001_1001;  // bit n-1: lit after tick n
        mode = 2'd1; commit_req = 1; frame_tick = 1;
        cyc();
        commit_req = 0; frame_tick = 0;
        checks++;
        if (leds !== F3) begin failures++; $display("FAIL blink_start got=%h exp=%h", leds, F3); end
        for (int n = 1; n <= 8; n++) begin
            frame_tick = 1;
            cyc();
            frame_tick = 0;
            checks++;
            if (leds !== (lit_tbl[n-1] ? F3 : F_ZERO)) begin
                failures++; $display("FAIL blink_tick%0d got=%h exp_lit=%b", n, leds, lit_tbl[n-1]);
            end
            checks++;
            if ({any_on, lit_count, led_index} !== {1'b1, 4'd5, 3'd0}) begin
                failures++; $display("FAIL blink_status%0d got any=%b cnt=%0d idx=%0d exp 1/5/0", n, any_on, lit_count, led_index);
            end
        end
        repeat (2) begin frame_tick = 1; cyc(); end
        frame_tick = 0;
        checks++;
        if (leds !== F_ZERO) begin failures++; $display("FAIL blink_pre_restart got=%h exp=0", leds); end
        commit_req = 1; frame_tick = 1;
        cyc();
        commit_req = 0;
        checks++;
        if ({commit_ack, leds} !== {1'b1, F3}) begin
            failures++; $display("FAIL blink_restart got ack=%b leds=%h exp ack=1 leds=%h", commit_ack, leds, F3);
        end
        cyc();
        checks++;
        if (leds !== F3) begin failures++; $display("FAIL blink_restart_t1 got=%h exp=%h", leds, F3); end
        cyc();
        frame_tick = 0;
        checks++;
        if (leds !== F_ZERO) begin failures++; $display("FAIL blink_restart_t2 got=%h exp=0", leds); end
    endtask

    task automatic test_wr_err();
        mode = 2'd0;
        wr_valid = 1; wr_index = 3'd7; wr_color = 24'hABCDEF;
        cyc();
        wr_valid = 0;
        checks++;
        if (wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_set got=%b exp=1", wr_err); end
        commit_req = 1; frame_tick = 1;
        cyc();
        commit_req = 0; frame_tick = 0;
        checks++;
        if (leds !== F3) begin failures++; $display("FAIL wr_err_no_change got=%h exp=%h", leds, F3); end
        wr_valid = 1; wr_index = 3'd0; wr_color = 24'h000001;
        repeat (3) cyc();
        wr_valid = 0;
        checks++;
        if (wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_sticky got=%b exp=1", wr_err); end
    endtask

    task automatic test_reset_pending();
        commit_req = 1;
        cyc();
        commit_req = 0;
        checks++;
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_pend_setup got=%b exp=0", wr_ready); end
        reset = 1'b1;
        #2;
        checks++;
        if (leds !== F_ZERO) begin failures++; $display("FAIL async_rst_leds got=%h exp=0", leds); end
        checks++;
        if ({wr_ready, wr_err, commit_ack, any_on, lit_count, led_index} !== {4'b1000, 4'd0, 3'd0}) begin
            failures++; $display("FAIL async_rst_ctrl got rdy=%b err=%b ack=%b any=%b cnt=%0d idx=%0d exp 1/0/0/0/0/0",
                                 wr_ready, wr_err, commit_ack, any_on, lit_count, led_index);
        end
        cyc();
        reset = 1'b0;
        frame_tick = 1;
        cyc();
        frame_tick = 0;
        cyc();
        checks++;
        if ({commit_ack, leds} !== {1'b0, F_ZERO}) begin
            failures++; $display("FAIL rst_no_commit got ack=%b leds=%h exp ack=0 leds=0", commit_ack, leds);
        end
    endtask

    initial begin
        test_reset();
        test_bulk_commit();
        test_pending_drop();
        test_same_cycle();
        test_blink();
        test_wr_err();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_frame_buffer_n.md
Name: led_frame_buffer_n

Overview:
Parametrised, double-buffered LED colour frame store for the game display path. It generalises the 5-LED load-mask decoder to N channels and COLOR_W colours. It adds per-LED write handshake, frame-synchronised commit, blink/off display modes, and lit-LED status outputs. It sits between game logic (writers) and the LED serialiser (consumer of the flat colour bus).

Parameters:
N_LEDS, 5, number of LED channels (2..32)
COLOR_W, 24, colour width per LED
IDX_W, $clog2(N_LEDS), width of index ports
BLINK_TICKS, 8, frame_ticks per blink half-period (>=1)

Ports:
clock  in  1  system clock
reset  in  1  reset
load_frame  in  1  bulk shadow load strobe
load_mask  in  N_LEDS  bulk select: bit i=1 -> shadow[i]=load_color, else 0
load_color  in  COLOR_W  bulk colour
wr_valid  in  1  single-LED write request
wr_ready  out  1  write/bulk accept (=!commit_pending)
wr_index  in  IDX_W  target LED
wr_color  in  COLOR_W  colour for wr_index
wr_err  out  1  sticky: accepted write with wr_index>=N_LEDS
mode  in  2  0 SOLID, 1 BLINK, 2 OFF, 3 reserved (treated as SOLID); sampled at commit
commit_req  in  1  request shadow->active copy
frame_tick  in  1  one-cycle frame boundary pulse from serialiser
commit_ack  out  1  one-cycle pulse in the cycle after the copy
leds  out  N_LEDS*COLOR_W  displayed colours, LED0 in LSBs
led_index  out  IDX_W  lowest index with non-zero active colour; 0 if none
any_on  out  1  any active colour non-zero
lit_count  out  IDX_W+1  number of non-zero active colours

Behaviour:
- Reset is asynchronous, active-high, on reset; clock is clock. On reset: shadow, active, leds=0; active mode=SOLID; commit_pending=0; wr_ready=1; wr_err=0; commit_ack=0; blink counter=0; phase=ON; led_index=0; any_on=0; lit_count=0.
- Shadow writes are accepted only when wr_ready=1. load_frame and wr_valid are both ignored while commit_pending=1, with no error.
- Bulk and single write in the same cycle: bulk applies to all LEDs, then the single write overrides its own index.
- Single write with wr_index>=N_LEDS is accepted but drops the data, and sets wr_err until reset.
- commit_req when not pending sets commit_pending=1 and drops wr_ready the next cycle. commit_req while pending is ignored.
- Copy occurs on the first frame_tick while pending: active<=shadow, active mode<=mode, pending<=0, blink counter<=0, phase<=ON. commit_ack pulses the next cycle.
- commit_req and frame_tick in the same cycle with no pending commit: copy happens that same cycle. The copied value is the merged next-shadow, so writes accepted in that cycle are included. pending never rises.
- frame_tick with nothing pending: only advances blink.
- Blink, in BLINK mode: the counter increments on each frame_tick. On reaching BLINK_TICKS-1 it wraps to 0 and phase toggles. A commit cycle overrides the blink advance.
- In SOLID and OFF modes, the counter and phase are held at 0/ON.
- Displayed leds are registered:
  - SOLID: active.
  - BLINK: active when phase=ON, 0 when OFF.
  - OFF: 0.
- leds reflect a commit one cycle after the copy cycle, i.e. the same cycle as commit_ack.
- Status outputs (led_index, any_on, lit_count) are registered and derived from active, not displayed, colours. They are stable across blink and OFF, and update with the same latency as leds.
- Reset mid-pending discards the pending commit and the shadow.

Decomposition:
- Shared package led_pkg: mode encoding constants (MODE_SOLID, MODE_BLINK, MODE_OFF) and a COLOR_OFF constant (all-zero).
- One sub-module, led_status_enc: a combinational priority-index plus popcount over N_LEDS non-zero flags, parametrised by N_LEDS.

Test Plan:
1. Reset, then load_frame with mask=5'b10100 and color=24'hFF0000, then commit_req with frame_tick 3 cycles later.
   - Response: leds[2] and leds[4]=FF0000, others 0; led_index=2; lit_count=2; any_on=1.
   - commit_ack pulses exactly once, in the same cycle leds update.
2. commit_req with no tick, then wr_valid(idx=1, color=00FF00) and load_frame while pending.
   - Response: wr_ready=0 and both writes are dropped.
   - After the next frame_tick, active equals the pre-request shadow.
3. Same-cycle load_frame (mask=all, color=0000FF) and wr_valid(idx=3, color=123456), with commit_req and frame_tick in that cycle and no pending commit.
   - Response: leds = 0000FF except leds[3]=123456, visible 1 cycle later; no wr_ready drop.
4. Commit with mode=BLINK and BLINK_TICKS=2, then 8 frame_ticks.
   - Response: leds alternate lit/0 every 2 ticks.
   - led_index and lit_count remain constant throughout.
   - A mid-blink commit restarts at phase ON.
5. wr_valid with wr_index=7 (N_LEDS=5).
   - Response: no shadow change; wr_err=1 and held until reset.
6. Assert reset while commit_pending=1.
   - Response: all outputs return to reset values asynchronously.
   - A subsequent frame_tick produces no commit_ack.
